// File: rtl/pipeline_stage_chain.sv
// pipeline_stage_chain
// Parametrised chain of pipeline registers with per-stage stall, flush,
// valid tracking and bubble insertion, plus saturating counters for
// last-stage bubbles and front-end stalls. Stage 0 is the IF/ID boundary,
// stage STAGES-1 feeds execute.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   in_data_i      payload presented to stage 0
//   in_valid_i     in_data_i carries a real instruction
//   in_ready_o     stage 0 loads this cycle (~hold[0], from stall only)
//   stall_i        per-stage hold request
//   flush_i        per-stage squash to a bubble (overrides hold)
//   stage_data_o   registered payloads, stage i at [i*WIDTH +: WIDTH]
//   stage_valid_o  registered valid per stage
//   bubble_cnt_o   cycles with last-stage valid low (saturating)
//   stall_cnt_o    cycles with in_ready_o low (saturating)
module pipeline_stage_chain #(
   parameter int                 WIDTH   = 32,
   parameter int                 STAGES  = 2,
   parameter logic [WIDTH-1:0]   NOP_VAL = '0,
   parameter int                 CNT_W   = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [WIDTH-1:0]          in_data_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [STAGES-1:0]         stall_i,
   input  logic [STAGES-1:0]         flush_i,
   output logic [STAGES*WIDTH-1:0]   stage_data_o,
   output logic [STAGES-1:0]         stage_valid_o,
   output logic [CNT_W-1:0]          bubble_cnt_o,
   output logic [CNT_W-1:0]          stall_cnt_o
);

   logic [STAGES-1:0] hold_w;
   logic [WIDTH-1:0]  src_data_w  [STAGES];
   logic [STAGES-1:0] src_valid_w;

   logic [WIDTH-1:0]  data_q  [STAGES];
   logic [WIDTH-1:0]  data_d  [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

   // A downstream hold freezes every upstream stage.
   always_comb begin
      hold_w = '0;
      hold_w[STAGES-1] = stall_i[STAGES-1];
      for (int i = STAGES - 2; i >= 0; i--) begin
         hold_w[i] = stall_i[i] | hold_w[i+1];
      end
   end

   assign in_ready_o = ~hold_w[0];

   // Source of each stage when it loads. A held predecessor feeds a bubble
   // downstream instead of duplicating its contents. An invalid input is
   // normalised to NOP_VAL so an empty stage never shows stale payload.
   for (genvar g = 0; g < STAGES; g++) begin : g_src
      if (g == 0) begin : g_first
         assign src_data_w[g]  = in_valid_i ? in_data_i : NOP_VAL;
         assign src_valid_w[g] = in_valid_i;
      end else begin : g_rest
         assign src_data_w[g]  = hold_w[g-1] ? NOP_VAL : data_q[g-1];
         assign src_valid_w[g] = ~hold_w[g-1] & valid_q[g-1];
      end
   end

   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         data_d[i]  = data_q[i];
         valid_d[i] = valid_q[i];
         if (flush_i[i]) begin
            data_d[i]  = NOP_VAL;
            valid_d[i] = 1'b0;
         end else if (!hold_w[i]) begin
            data_d[i]  = src_data_w[i];
            valid_d[i] = src_valid_w[i];
         end
      end

      bubble_cnt_d = bubble_cnt_q;
      if (!valid_q[STAGES-1] && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (hold_w[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= NOP_VAL;
         end
         valid_q      <= '0;
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
         end
         valid_q      <= valid_d;
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_out
      assign stage_data_o[g*WIDTH +: WIDTH] = data_q[g];
   end

   assign stage_valid_o = valid_q;
   assign bubble_cnt_o  = bubble_cnt_q;
   assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/pipeline_stage_chain.md
# pipeline_stage_chain

Parametrised chain of pipeline registers with per-stage stall, flush, valid tracking and bubble insertion. It generalises the fixed inter-stage registers between instruction_fetch, instruction_decode and execute into one block with configurable stage count and width. It also carries saturating performance counters for bubbles and front-end stalls. In the processor top level, stage 0 is the IF/ID boundary and stage STAGES-1 feeds execute.

## Interface
- WIDTH, 32: payload bits per stage (instruction word plus sideband).
- STAGES, 2: number of register stages, legal range 1 to 8.
- NOP_VAL, 32'h0000_0000: payload loaded on reset, flush and bubble. Width WIDTH.
- CNT_W, 16: width of each performance counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  payload presented to stage 0.
- in_valid  in  1  in_data carries a real instruction.
- in_ready  out  1  stage 0 will load this cycle; equals ~hold[0].
- stall  in  STAGES  per-stage hold request; bit i holds stage i.
- flush  in  STAGES  per-stage squash; bit i forces stage i to a bubble.
- stage_data  out  STAGES*WIDTH  registered payloads; stage i occupies bits [i*WIDTH +: WIDTH].
- stage_valid  out  STAGES  registered valid bit per stage.
- bubble_cnt  out  CNT_W  cycles in which stage_valid[STAGES-1] was 0.
- stall_cnt  out  CNT_W  cycles in which in_ready was 0.

## Operation
Hold terms are combinational, computed from the last stage upward:
- hold[STAGES-1] = stall[STAGES-1]
- hold[i] = stall[i] | hold[i+1]
- A downstream hold therefore freezes every upstream stage (lockstep stall).

Next state for stage i, highest priority first:
- rst: data = NOP_VAL, valid = 0.
- flush[i]: data = NOP_VAL, valid = 0. Flush overrides hold.
- hold[i]: retain current data and valid.
- i == 0: load in_data and in_valid.
- i > 0 and hold[i-1]: load a bubble (NOP_VAL, valid 0). This is bubble insertion; stage i-1 keeps its contents.
- i > 0 otherwise: load stage i-1's current data and valid.

Flush rules:
- A flush of stage i does not stop stage i's current contents moving into stage i+1 on the same edge.
- The block never suppresses propagation. A squash that must also kill the downstream copy must assert both flush bits.

Input handling:
- When in_ready is 0, in_data and in_valid are ignored. The source must keep them stable until in_ready is 1.
- Payload passes through unmodified and is never interpreted.
- When valid is 0, data is exactly NOP_VAL, never stale payload.

Counters:
- Both counters clear on rst.
- Each increments by 1 per qualifying cycle (condition sampled before the edge).
- Each saturates at 2^CNT_W-1 and never wraps.
- Increments continue during stalls and flushes.

## Timing
- Reset values: stage_data = all NOP_VAL, stage_valid = 0, bubble_cnt = 0, stall_cnt = 0.
- During rst, in_ready follows ~hold[0] combinationally; loads are ignored.
- Latency: with no stall and no flush, in_data accepted at edge N appears on stage k at edge N+k, i.e. visible in the cycle after edge N+k.
- in_ready is combinational from stall only. There is no path from in_valid to in_ready.
- Simultaneous stall[i] and flush[i]: stage i becomes a bubble. Upstream stages still hold because hold propagates upward regardless of flush.
- rst asserted mid-stall or mid-flush: everything clears at that edge. The first load occurs at the first edge with rst low.
- STAGES = 1: stage 0 is both first and last. bubble_cnt tracks stage_valid[0].

## Test plan
- Streaming, STAGES=2:
  - Stimulus: after reset, present 0x11, 0x22, 0x33 with in_valid=1 on consecutive cycles.
  - Required: stage 1 shows 0x11, 0x22, 0x33 on cycles 2, 3, 4; stall_cnt stays 0; bubble_cnt = 2 at cycle 2.
- Last-stage stall:
  - Stimulus: stall[1]=1 for 3 cycles with 0xA in stage 1 and 0xB in stage 0.
  - Required: both stages hold; in_ready=0; stall_cnt += 3; input 0xC is loaded only after stall drops.
- Bubble insertion:
  - Stimulus: stall[0]=1 for 1 cycle with 0xB in stage 0 and 0xA in stage 1.
  - Required: next cycle stage 1 = NOP_VAL with valid 0 and stage 0 still 0xB; the cycle after, stage 1 = 0xB.
- Flush while held:
  - Stimulus: stall[1]=1 and flush[1]=1 together, stage 1 = 0xA.
  - Required: stage 1 = NOP_VAL with valid 0; stage 0 unchanged.
- Flush does not block propagation:
  - Stimulus: flush[0] pulse with stage 0 = 0x55.
  - Required: stage 1 = 0x55 with valid 1; stage 0 becomes a bubble.
- Counter saturation and reset:
  - Stimulus: CNT_W=4, in_valid=0 for 20 cycles.
  - Required: bubble_cnt stops at 15. Then rst for 1 cycle: all outputs return to their reset values.
